// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory responder slice.
// funct3 encodings and the responder FSM state type.
package cpu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// Also classifies funct3 legality and natural alignment.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] word_rd,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_ext,
    output logic        misalign,
    output logic        illegal_f3
);

    logic [31:0] shifted;
    logic [7:0]  byteV;
    logic [15:0] halfV;

    assign shifted = word_rd >> {addr, 3'b000};
    assign byteV   = shifted[7:0];
    assign halfV   = addr[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wr_word    = 32'h0;
        rd_ext     = 32'h0;
        misalign   = 1'b0;
        illegal_f3 = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: begin
                byte_en = 4'b0001 << addr;
                wr_word = {4{wdata[7:0]}};
                rd_ext  = {{24{byteV[7] & ~funct3[2]}}, byteV};
            end
            F3_H, F3_HU: begin
                misalign = addr[0];
                byte_en  = addr[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{wdata[15:0]}};
                rd_ext   = {{16{halfV[15] & ~funct3[2]}}, halfV};
            end
            F3_W: begin
                misalign = (addr != 2'b00);
                byte_en  = 4'b1111;
                wr_word  = wdata;
                rd_ext   = word_rd;
            end
            default: illegal_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind the Mem stage: fixed-latency busywait,
// RV32I lane handling, and one-cycle completion / error pulses.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        busywait,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign_err,
    output logic        illegal_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY < 3) ? 1 : $clog2(LATENCY - 1);
    localparam logic [CW-1:0] CNT_INIT =
        (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] cnt;
    logic          goDone;

    logic [AW+1:0] addrQ;
    logic [31:0]   wdataQ;
    logic [2:0]    f3Q;
    logic          rdQ;
    logic          wrQ;

    logic          req;
    logic          inIdle;
    logic [AW+1:0] selAddr;
    logic [31:0]   selWdata;
    logic [2:0]    selF3;
    logic          selRd;
    logic          selWr;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wordIdx;
    logic [31:0]   wordRd;
    logic [3:0]    byteEn;
    logic [31:0]   wrWord;
    logic [31:0]   rdExt;
    logic          misF3;
    logic          illF3;
    logic          isIll;
    logic          isMis;
    logic          memWe;
    logic          unusedAddr;

    assign unusedAddr = ^addr[31:AW+2];

    assign req    = mem_read | mem_write;
    assign inIdle = (state == IDLE);

    // With LATENCY=1 the access completes from IDLE, so it sees live inputs.
    assign selAddr  = inIdle ? addr[AW+1:0] : addrQ;
    assign selWdata = inIdle ? wdata : wdataQ;
    assign selF3    = inIdle ? funct3 : f3Q;
    assign selRd    = inIdle ? mem_read : rdQ;
    assign selWr    = inIdle ? mem_write : wrQ;

    assign wordIdx = selAddr[AW+1:2];
    assign wordRd  = mem[wordIdx];

    mem_lane_align uAlign (
        .addr      (selAddr[1:0]),
        .funct3    (selF3),
        .wdata     (selWdata),
        .word_rd   (wordRd),
        .byte_en   (byteEn),
        .wr_word   (wrWord),
        .rd_ext    (rdExt),
        .misalign  (misF3),
        .illegal_f3(illF3)
    );

    // Stores only exist for B/H/W, so funct3[2] set on a store is illegal.
    assign isIll = illF3 | (selRd & selWr) | (selWr & selF3[2]);
    assign isMis = misF3 & ~isIll;
    assign memWe = goDone & selWr & ~isIll & ~isMis & ~reset;

    always_comb begin
        nextState = state;
        busywait  = 1'b0;
        goDone    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    busywait = 1'b1;
                    if (LATENCY == 1) begin
                        nextState = DONE;
                        goDone    = 1'b1;
                    end else begin
                        nextState = ACCESS;
                    end
                end
            end
            ACCESS: begin
                busywait = 1'b1;
                if (cnt == '0) begin
                    nextState = DONE;
                    goDone    = 1'b1;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (reset) begin
            busywait = 1'b0;
            goDone   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addrQ        <= '0;
            wdataQ       <= 32'h0;
            f3Q          <= 3'b000;
            rdQ          <= 1'b0;
            wrQ          <= 1'b0;
            rdata        <= 32'h0;
            rvalid       <= 1'b0;
            misalign_err <= 1'b0;
            illegal_err  <= 1'b0;
        end else begin
            state        <= nextState;
            rvalid       <= goDone & selRd & ~isIll & ~isMis;
            misalign_err <= goDone & isMis;
            illegal_err  <= goDone & isIll;
            if (inIdle && req) begin
                addrQ  <= addr[AW+1:0];
                wdataQ <= wdata;
                f3Q    <= funct3;
                rdQ    <= mem_read;
                wrQ    <= mem_write;
                cnt    <= CNT_INIT;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (goDone) begin
                if (isIll || isMis) begin
                    rdata <= 32'h0;
                end else if (selRd) begin
                    rdata <= rdExt;
                end
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=3 and LATENCY=1 builds.
// Driver pushes expected completions; negedge monitors pop and compare.
module tb_data_mem_responder;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic        bw0, rv0, mis0, ill0;
    logic        bw1, rv1, mis1, ill1;
    logic [31:0] rdata0, rdata1;

    typedef struct packed {
        logic [31:0] rd;
        logic        rv;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
        .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0),
        .addr(addr), .wdata(wdata), .funct3(f3), .busywait(bw0),
        .rdata(rdata0), .rvalid(rv0), .misalign_err(mis0),
        .illegal_err(ill0)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
        .addr(addr), .wdata(wdata), .funct3(f3), .busywait(bw1),
        .rdata(rdata1), .rvalid(rv1), .misalign_err(mis1),
        .illegal_err(ill1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (rv0 || mis0 || ill0)) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d0 unexpected pulse rv=%b mis=%b ill=%b",
                         rv0, mis0, ill0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("d0 rvalid", {31'b0, rv0}, {31'b0, e.rv});
                chk("d0 misalign", {31'b0, mis0}, {31'b0, e.mis});
                chk("d0 illegal", {31'b0, ill0}, {31'b0, e.ill});
                chk("d0 rdata", rdata0, e.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (rv1 || mis1 || ill1)) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1 unexpected pulse rv=%b mis=%b ill=%b",
                         rv1, mis1, ill1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1 rvalid", {31'b0, rv1}, {31'b0, e.rv});
                chk("d1 misalign", {31'b0, mis1}, {31'b0, e.mis});
                chk("d1 illegal", {31'b0, ill1}, {31'b0, e.ill});
                chk("d1 rdata", rdata1, e.rd);
            end
        end
    end

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic doReq(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] fn);
        int n;
        int lat;
        n   = 0;
        lat = (d == 0) ? 3 : 1;
        @(negedge clk);
        addr  = a;
        wdata = wd;
        f3    = fn;
        if (d == 0) begin
            rd0 = r;
            wr0 = w;
        end else begin
            rd1 = r;
            wr1 = w;
        end
        #1;
        while ((d == 0 ? bw0 : bw1) && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        rd0 = 1'b0;
        wr0 = 1'b0;
        rd1 = 1'b0;
        wr1 = 1'b0;
        chk($sformatf("d%0d busy cycles a=%h", d, a), 32'(n), 32'(lat));
    endtask

    task automatic ld(input int d, input logic [31:0] a,
                      input logic [2:0] fn, input logic [31:0] v);
        push(d, '{rd: v, rv: 1'b1, mis: 1'b0, ill: 1'b0});
        doReq(d, 1'b1, 1'b0, a, 32'h0, fn);
    endtask

    task automatic st(input int d, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] fn);
        doReq(d, 1'b0, 1'b1, a, wd, fn);
    endtask

    task automatic errReq(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] fn, input logic isMis);
        push(d, '{rd: 32'h0, rv: 1'b0, mis: isMis, ill: ~isMis});
        doReq(d, r, w, a, wd, fn);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        addr = 32'h0; wdata = 32'h0; f3 = F3_W;
        repeat (2) @(negedge clk);
        chk("reset busywait", {31'b0, bw0}, 32'h0);
        chk("reset rdata", rdata0, 32'h0);
        chk("reset pulses", {29'b0, rv0, mis0, ill0}, 32'h0);
        reset = 1'b0;

        st(0, 32'h10, 32'hDEADBEEF, F3_W);
        ld(0, 32'h10, F3_W, 32'hDEADBEEF);
        st(0, 32'h11, 32'h0000007F, F3_B);
        ld(0, 32'h10, F3_W, 32'hDEAD7FEF);
        ld(0, 32'h13, F3_B, 32'hFFFFFFDE);
        ld(0, 32'h13, F3_BU, 32'h000000DE);
        ld(0, 32'h12, F3_H, 32'hFFFFDEAD);
        ld(0, 32'h12, F3_HU, 32'h0000DEAD);
        ld(0, 32'h11, F3_B, 32'h0000007F);

        errReq(0, 1'b1, 1'b0, 32'h12, 32'h0, F3_W, 1'b1);
        errReq(0, 1'b0, 1'b1, 32'h11, 32'h1234, F3_H, 1'b1);
        ld(0, 32'h10, F3_W, 32'hDEAD7FEF);
        errReq(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0);
        errReq(0, 1'b1, 1'b1, 32'h10, 32'h0, F3_W, 1'b0);
        errReq(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_BU, 1'b0);
        ld(0, 32'h10, F3_W, 32'hDEAD7FEF);

        st(0, 32'h20, 32'h11223344, F3_W);
        @(negedge clk);
        addr  = 32'h20;
        wdata = 32'hA5A5A5A5;
        f3    = F3_W;
        wr0   = 1'b1;
        #1 chk("abort 1st busy", {31'b0, bw0}, 32'h1);
        @(negedge clk);
        #1 chk("abort 2nd busy", {31'b0, bw0}, 32'h1);
        reset = 1'b1;
        wr0   = 1'b0;
        #1 chk("abort busy drop", {31'b0, bw0}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ld(0, 32'h20, F3_W, 32'h11223344);

        st(1, 32'h0, 32'hCAFEF00D, F3_W);
        ld(1, 32'h0, F3_W, 32'hCAFEF00D);
        ld(1, 32'h400, F3_W, 32'hCAFEF00D);
        st(1, 32'h404, 32'h00000055, F3_W);
        ld(1, 32'h4, F3_W, 32'h00000055);
        ld(1, 32'h3, F3_B, 32'hFFFFFFCA);

        repeat (3) @(negedge clk);
        chk("d0 queue drained", 32'(q0.size()), 32'h0);
        chk("d1 queue drained", 32'(q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder on the far side of the CPU memory stage. It accepts load and store requests from the Mem stage and holds a busywait stall for a fixed latency. It then completes the access with RISC-V byte, half and word lane handling, and sign or zero extension on loads. Misaligned and illegal requests are reported with error pulses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of 2.
LATENCY, 3, cycles busywait stays high per request, counting the request cycle; legal range is 1 or more.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
mem_read  in  1  load request; held stable by the requester while busywait=1.
mem_write  in  1  store request; held stable by the requester while busywait=1.
addr  in  32  byte address.
wdata  in  32  store data; the lane source is its low bits.
funct3  in  3  access size and signedness (RV32I load/store funct3).
busywait  out  1  stall to the pipeline.
rdata  out  32  aligned, extended load result.
rvalid  out  1  one-cycle pulse; a load has completed.
misalign_err  out  1  one-cycle pulse; the access was misaligned.
illegal_err  out  1  one-cycle pulse; illegal funct3, or read and write asserted together.

Behaviour:
- Reset (async): state goes to IDLE; busywait, rvalid, misalign_err and illegal_err go to 0; rdata goes to 0; the latency counter clears; any pending store is discarded. Array contents are NOT cleared.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, with mem_read or mem_write high:
  - latch addr, wdata, funct3 and op;
  - busywait=1 combinationally in this same cycle;
  - next state is ACCESS with counter=LATENCY-2 if LATENCY>=2, otherwise DONE.
- IDLE with no request: busywait=0 and the state stays IDLE.
- ACCESS: busywait=1. Move to DONE when the counter is 0, otherwise decrement. ACCESS lasts LATENCY-1 cycles.
- Request to DONE transition:
  - legal store: commit the masked write to the array;
  - legal load: register rdata from the array.
- DONE, lasting one cycle:
  - busywait=0;
  - rvalid=1 for a legal load;
  - misalign_err or illegal_err=1 when flagged;
  - next state is IDLE unconditionally. A request seen during DONE is ignored; the requester has advanced, and a new request starts next cycle.
- busywait high time per request is exactly LATENCY cycles. Back-to-back requests incur one idle cycle between them.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 101 LHU: zero-extend the selected half.
  - 010 LW: full word.
  - Lane selection: byte lane is addr[1:0]; half lane is addr[1].
- Stores: 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are written; other bytes are preserved.
- Misaligned cases are a halfword access with addr[0]=1, or a word access with addr[1:0]≠0. Result: no array write, rdata=0, rvalid=0, misalign_err=1 in DONE.
- Illegal cases are any other funct3, or mem_read and mem_write both high. Result: no write, rdata=0, illegal_err=1 in DONE. Illegal takes precedence over misaligned.
- rdata holds its last value outside DONE. It is overwritten only on a load completion, or cleared to 0 on an erroneous completion.
- Reset asserted mid-ACCESS: the write is not committed, and no pulse is produced.

Decomposition:
- Shared package (cpu_mem_pkg):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum IDLE/ACCESS/DONE.
- One combinational sub-module, mem_lane_align:
  - inputs: addr[1:0], funct3, wdata, word_rd;
  - outputs: byte_en[3:0], wr_word, rd_ext, misalign, illegal_f3.
- The top module holds the FSM, counter, latches and array.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, LATENCY=3 -> busywait high exactly 3 cycles; then LW 0x10 -> rdata=0xDEADBEEF with a 1-cycle rvalid.
- After the above, SB addr=0x11, wdata=0x7F; then LW 0x10 -> 0xDEAD7FEF. LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD.
- LW addr=0x12 -> misalign_err pulse, rdata=0, rvalid=0. SH addr=0x11, wdata=0x1234 -> misalign_err, and a following LW 0x10 is unchanged.
- funct3=011 with mem_read -> illegal_err. mem_read and mem_write both high -> illegal_err, no write.
- Reset asserted in the 2nd busywait cycle of SW 0x20=0xA5A5A5A5 -> busywait=0 at once, no pulse; a following LW 0x20 returns the previous contents.
- LATENCY=1 build: SW then LW at 0x0 -> busywait high 1 cycle per request, rvalid in the next cycle. Addr 0x400 (DEPTH_WORDS=256) aliases to 0x0.
